// File: rtl/mem_bus_master.sv
// MEM-stage data-bus master: turns a single-cycle load/store request into a req/ack bus
// transaction, stalls the pipeline while it is outstanding and holds load data across stalls.
module mem_bus_master #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cpu_ce_i,
    input  logic                cpu_we_i,
    input  logic [ADDR_W-1:0]   cpu_addr_i,
    input  logic [DATA_W-1:0]   cpu_data_i,
    input  logic [DATA_W/8-1:0] cpu_sel_i,
    output logic [DATA_W-1:0]   cpu_data_o,
    output logic                stallreq_o,
    input  logic [5:0]          stall_i,
    input  logic                flush_i,
    output logic                bus_req_o,
    output logic                bus_we_o,
    output logic [ADDR_W-1:0]   bus_addr_o,
    output logic [DATA_W-1:0]   bus_data_o,
    output logic [DATA_W/8-1:0] bus_sel_o,
    input  logic [DATA_W-1:0]   bus_data_i,
    input  logic                bus_ack_i,
    output logic                bus_err_o
);

    localparam int SEL_W = DATA_W / 8;
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_HOLD,
        S_ABORT
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_rd_buf;
    logic                r_bus_req;
    logic                r_bus_we;
    logic [ADDR_W-1:0]   r_bus_addr;
    logic [DATA_W-1:0]   r_bus_data;
    logic [SEL_W-1:0]    r_bus_sel;
    logic                r_bus_err;

    logic                w_issue;
    logic                w_req_clr;
    logic                w_err_set;
    logic                w_rd_buf_ld;
    logic [DATA_W-1:0]   w_rd_buf_nxt;
    logic                w_timeout;
    logic                w_stalled;

    assign w_timeout = (TIMEOUT != 0) && (r_cnt == CNT_W'(TIMEOUT - 1));
    assign w_stalled = (stall_i != 6'b0);

    // NOTE: every combinational output gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_nxt  = r_state;
        w_issue      = 1'b0;
        w_req_clr    = 1'b0;
        w_err_set    = 1'b0;
        w_rd_buf_ld  = 1'b0;
        w_rd_buf_nxt = '0;
        stallreq_o   = 1'b0;
        cpu_data_o   = '0;

        unique case (r_state)
            S_IDLE: begin
                stallreq_o = cpu_ce_i & ~flush_i;
                if (cpu_ce_i && !flush_i) begin
                    w_issue     = 1'b1;
                    w_state_nxt = S_BUSY;
                end
            end

            S_BUSY: begin
                if (flush_i) begin
                    // The bus cycle is never cut short: a flush without ack keeps req up in ABORT.
                    if (bus_ack_i) begin
                        w_req_clr   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        stallreq_o  = 1'b1;
                        w_state_nxt = S_ABORT;
                    end
                end else if (bus_ack_i) begin
                    cpu_data_o   = r_bus_we ? '0 : bus_data_i;
                    w_rd_buf_ld  = 1'b1;
                    w_rd_buf_nxt = r_bus_we ? '0 : bus_data_i;
                    w_req_clr    = 1'b1;
                    w_state_nxt  = w_stalled ? S_HOLD : S_IDLE;
                end else if (w_timeout) begin
                    w_rd_buf_ld  = 1'b1;
                    w_req_clr    = 1'b1;
                    w_err_set    = 1'b1;
                    w_state_nxt  = w_stalled ? S_HOLD : S_IDLE;
                end else begin
                    stallreq_o = 1'b1;
                end
            end

            S_HOLD: begin
                cpu_data_o = r_rd_buf;
                if (flush_i || !w_stalled) begin
                    w_state_nxt = S_IDLE;
                end
            end

            S_ABORT: begin
                stallreq_o = cpu_ce_i;
                if (bus_ack_i || w_timeout) begin
                    w_req_clr   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end

            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bus_req  <= 1'b0;
            r_bus_we   <= 1'b0;
            r_bus_addr <= '0;
            r_bus_data <= '0;
            r_bus_sel  <= '0;
            r_bus_err  <= 1'b0;
            r_cnt      <= '0;
            r_rd_buf   <= '0;
        end else begin
            r_bus_err <= w_err_set;

            if (w_issue) begin
                r_bus_req  <= 1'b1;
                r_bus_we   <= cpu_we_i;
                r_bus_addr <= cpu_addr_i;
                r_bus_data <= cpu_data_i;
                r_bus_sel  <= cpu_sel_i;
            end else if (w_req_clr) begin
                r_bus_req  <= 1'b0;
            end

            // Counter keeps running through ABORT so an unanswered aborted cycle still times out.
            if (w_issue) begin
                r_cnt <= '0;
            end else if ((r_state == S_BUSY || r_state == S_ABORT) && r_cnt != CNT_W'(TIMEOUT)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            if (w_rd_buf_ld) begin
                r_rd_buf <= w_rd_buf_nxt;
            end
        end
    end

    assign bus_req_o  = r_bus_req;
    assign bus_we_o   = r_bus_we;
    assign bus_addr_o = r_bus_addr;
    assign bus_data_o = r_bus_data;
    assign bus_sel_o  = r_bus_sel;
    assign bus_err_o  = r_bus_err;

endmodule

// File: tb/tb_mem_bus_master.sv
// Directed bench for mem_bus_master: load, store, hold-under-stall, flush/abort, timeout and
// asynchronous reset, each with hand-computed expectations.
module tb_mem_bus_master;

    logic        clk;
    logic        rst;
    logic        cpu_ce_i;
    logic        cpu_we_i;
    logic [31:0] cpu_addr_i;
    logic [31:0] cpu_data_i;
    logic [3:0]  cpu_sel_i;
    logic [31:0] cpu_data_o;
    logic        stallreq_o;
    logic [5:0]  stall_i;
    logic        flush_i;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_data_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_data_i;
    logic        bus_ack_i;
    logic        bus_err_o;

    int total = 0;
    int bad   = 0;

    mem_bus_master #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_ce_i   (cpu_ce_i),
        .cpu_we_i   (cpu_we_i),
        .cpu_addr_i (cpu_addr_i),
        .cpu_data_i (cpu_data_i),
        .cpu_sel_i  (cpu_sel_i),
        .cpu_data_o (cpu_data_o),
        .stallreq_o (stallreq_o),
        .stall_i    (stall_i),
        .flush_i    (flush_i),
        .bus_req_o  (bus_req_o),
        .bus_we_o   (bus_we_o),
        .bus_addr_o (bus_addr_o),
        .bus_data_o (bus_data_o),
        .bus_sel_o  (bus_sel_o),
        .bus_data_i (bus_data_i),
        .bus_ack_i  (bus_ack_i),
        .bus_err_o  (bus_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; checks happen 1 unit after that.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst        = 1'b0;
        cpu_ce_i   = 1'b0;
        cpu_we_i   = 1'b0;
        cpu_addr_i = '0;
        cpu_data_i = '0;
        cpu_sel_i  = '0;
        stall_i    = '0;
        flush_i    = 1'b0;
        bus_data_i = '0;
        bus_ack_i  = 1'b0;

        #2;
        check("rst_req",   bus_req_o,  0);
        check("rst_stall", stallreq_o, 0);
        check("rst_data",  cpu_data_o, 0);
        check("rst_err",   bus_err_o,  0);
        check("rst_addr",  bus_addr_o, 0);
        tick();
        tick();
        rst = 1'b1;
        tick();

        // Load 0x100, acked on the fourth request cycle
        cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h100; cpu_sel_i = 4'hF;
        settle();
        check("ld_c0_stall", stallreq_o, 1);
        check("ld_c0_data",  cpu_data_o, 0);
        tick();
        cpu_ce_i = 1'b0;
        settle();
        check("ld_c1_req",   bus_req_o,  1);
        check("ld_c1_addr",  bus_addr_o, 32'h100);
        check("ld_c1_we",    bus_we_o,   0);
        check("ld_c1_stall", stallreq_o, 1);
        tick();
        check("ld_c2_stall", stallreq_o, 1);
        tick();
        check("ld_c3_stall", stallreq_o, 1);
        check("ld_c3_req",   bus_req_o,  1);
        tick();
        bus_ack_i = 1'b1; bus_data_i = 32'hDEADBEEF;
        settle();
        check("ld_c4_stall", stallreq_o, 0);
        check("ld_c4_data",  cpu_data_o, 32'hDEADBEEF);
        tick();
        bus_ack_i = 1'b0; bus_data_i = '0;
        settle();
        check("ld_c5_req",   bus_req_o,  0);
        check("ld_c5_data",  cpu_data_o, 0);
        check("ld_c5_stall", stallreq_o, 0);

        // Store 0x55AA_1234 to 0x200 with sel 0011, acked on first request cycle
        cpu_ce_i = 1'b1; cpu_we_i = 1'b1; cpu_addr_i = 32'h200;
        cpu_data_i = 32'h55AA_1234; cpu_sel_i = 4'b0011;
        tick();
        cpu_ce_i = 1'b0; cpu_we_i = 1'b0;
        settle();
        check("st_req",  bus_req_o,  1);
        check("st_we",   bus_we_o,   1);
        check("st_sel",  bus_sel_o,  4'b0011);
        check("st_wdat", bus_data_o, 32'h55AA_1234);
        check("st_addr", bus_addr_o, 32'h200);
        bus_ack_i = 1'b1; bus_data_i = 32'hFFFF_FFFF;
        settle();
        check("st_ack_data",  cpu_data_o, 0);
        check("st_ack_stall", stallreq_o, 0);
        tick();
        bus_ack_i = 1'b0; bus_data_i = '0;
        settle();
        check("st_req_drop", bus_req_o, 0);

        // Load acked while the pipeline is stalled elsewhere -> HOLD
        cpu_ce_i = 1'b1; cpu_addr_i = 32'h300; cpu_sel_i = 4'hF;
        tick();
        cpu_ce_i = 1'b0;
        stall_i = 6'b001111; bus_ack_i = 1'b1; bus_data_i = 32'h1234_5678;
        settle();
        check("hold_ack_data", cpu_data_o, 32'h1234_5678);
        tick();
        bus_ack_i = 1'b0; bus_data_i = '0; cpu_ce_i = 1'b1; cpu_addr_i = 32'h3F0;
        settle();
        check("hold_data",  cpu_data_o, 32'h1234_5678);
        check("hold_stall", stallreq_o, 0);
        check("hold_req",   bus_req_o,  0);
        tick();
        check("hold2_req",  bus_req_o,  0);
        check("hold2_data", cpu_data_o, 32'h1234_5678);
        check("hold2_addr", bus_addr_o, 32'h300);
        stall_i = '0; cpu_ce_i = 1'b0;
        settle();
        check("hold3_data", cpu_data_o, 32'h1234_5678);
        tick();
        check("hold_exit_data", cpu_data_o, 0);
        check("hold_exit_req",  bus_req_o,  0);
        cpu_ce_i = 1'b1; cpu_addr_i = 32'h340;
        settle();
        check("hold_exit_idle", stallreq_o, 1);
        tick();
        cpu_ce_i = 1'b0;
        check("post_hold_req",  bus_req_o,  1);
        check("post_hold_addr", bus_addr_o, 32'h340);
        bus_ack_i = 1'b1; bus_data_i = 32'hA5A5_A5A5;
        tick();
        bus_ack_i = 1'b0; bus_data_i = '0;
        settle();
        check("post_hold_done", bus_req_o, 0);

        // Flush during BUSY, ack two cycles later while in ABORT
        cpu_ce_i = 1'b1; cpu_addr_i = 32'h400;
        tick();
        flush_i = 1'b1;
        settle();
        check("fl_c1_stall", stallreq_o, 1);
        tick();
        flush_i = 1'b0;
        settle();
        check("fl_c2_req",   bus_req_o,  1);
        check("fl_c2_stall", stallreq_o, 1);
        tick();
        bus_ack_i = 1'b1; bus_data_i = 32'hCAFE_F00D;
        settle();
        check("fl_ack_data",  cpu_data_o, 0);
        check("fl_ack_stall", stallreq_o, 1);
        check("fl_ack_req",   bus_req_o,  1);
        tick();
        bus_ack_i = 1'b0; bus_data_i = '0; cpu_addr_i = 32'h404;
        settle();
        check("fl_idle_req",   bus_req_o,  0);
        check("fl_idle_data",  cpu_data_o, 0);
        check("fl_idle_stall", stallreq_o, 1);
        tick();
        cpu_ce_i = 1'b0;
        check("fl_new_req",  bus_req_o,  1);
        check("fl_new_addr", bus_addr_o, 32'h404);
        bus_ack_i = 1'b1; bus_data_i = 32'h1111_1111;
        settle();
        check("fl_new_data", cpu_data_o, 32'h1111_1111);
        tick();
        bus_ack_i = 1'b0; bus_data_i = '0;

        // Timeout with TIMEOUT=8: eight request cycles, then a single error pulse
        cpu_ce_i = 1'b1; cpu_addr_i = 32'h500;
        tick();
        cpu_ce_i = 1'b0;
        settle();
        for (int i = 1; i <= 8; i++) begin
            check($sformatf("to_c%0d_req", i),   bus_req_o,  1);
            check($sformatf("to_c%0d_stall", i), stallreq_o, (i == 8) ? 1'b0 : 1'b1);
            check($sformatf("to_c%0d_err", i),   bus_err_o,  0);
            tick();
        end
        check("to_c8_data_next", cpu_data_o, 0);
        check("to_c9_req",   bus_req_o,  0);
        check("to_c9_err",   bus_err_o,  1);
        check("to_c9_stall", stallreq_o, 0);
        tick();
        check("to_c10_err", bus_err_o, 0);

        // Asynchronous reset between edges while BUSY
        cpu_ce_i = 1'b1; cpu_addr_i = 32'h600;
        tick();
        cpu_ce_i = 1'b0;
        check("ar_busy_req", bus_req_o, 1);
        #1;
        rst = 1'b0;
        #1;
        check("ar_req_drop", bus_req_o,  0);
        check("ar_stall",    stallreq_o, 0);
        tick();
        tick();
        rst = 1'b1;
        settle();
        check("ar_post_req",  bus_req_o,  0);
        check("ar_post_addr", bus_addr_o, 0);
        check("ar_post_data", cpu_data_o, 0);
        check("ar_post_err",  bus_err_o,  0);
        cpu_ce_i = 1'b1;
        settle();
        check("ar_post_idle", stallreq_o, 1);
        cpu_ce_i = 1'b0;
        tick();
        check("ar_no_issue", bus_req_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
